// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the prio_event_encoder block and its sub-modules.
package prio_enc_pkg;

  localparam int PRIO_MSB_FIRST = 0;
  localparam int PRIO_LSB_FIRST = 1;

  localparam int PRIO_WIDTH_MIN = 2;
  localparam int PRIO_WIDTH_MAX = 64;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Purely combinational priority encoder; LSB_HIGH selects whether the lowest or highest set bit wins.
module prio_enc_comb
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int LSB_HIGH = PRIO_MSB_FIRST,
  localparam int IDX_W    = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Later loop iterations override earlier ones, so the scan order puts the winner last.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LSB_HIGH == PRIO_LSB_FIRST) begin
        if (vec_i[WIDTH-1-i]) idx_o = IDX_W'(WIDTH - 1 - i);
      end else begin
        if (vec_i[i]) idx_o = IDX_W'(i);
      end
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/prio_event_encoder.sv
// Sticky event capture with registered priority index, ack-driven service and overflow flag.
// Optional mask port enabled by defining PRIO_EVENT_ENCODER_MASK_EN.
module prio_event_encoder
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int LSB_HIGH = PRIO_MSB_FIRST,
  localparam int IDX_W    = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             ack,
  input  logic             clr,
`ifdef PRIO_EVENT_ENCODER_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic [IDX_W-1:0] y,
  output logic             v,
  output logic [WIDTH-1:0] pend,
  output logic             ovf
);

  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] served;
  logic [WIDTH-1:0] eligible;
  logic [IDX_W-1:0] y_q, y_d;
  logic             v_q, v_d;
  logic             ovf_q, ovf_d;

  // A new pulse is ORed in after the serve clears, so a same-edge set of the served bit wins.
  always_comb begin
    served = '0;
    if (v_q && ack) served = {{(WIDTH-1){1'b0}}, 1'b1} << y_q;
    pend_d = (pend_q & ~served) | d;
    ovf_d  = ovf_q | (|(d & pend_q & ~served));
    if (clr) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end
  end

`ifdef PRIO_EVENT_ENCODER_MASK_EN
  assign eligible = pend_d & ~mask;
`else
  assign eligible = pend_d;
`endif

  prio_enc_comb #(
    .WIDTH   (WIDTH),
    .LSB_HIGH(LSB_HIGH)
  ) u_enc (
    .vec_i(eligible),
    .idx_o(y_d),
    .any_o(v_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      y_q    <= '0;
      v_q    <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      y_q    <= y_d;
      v_q    <= v_d;
      ovf_q  <= ovf_d;
    end
  end

  assign y    = y_q;
  assign v    = v_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/prio_event_encoder.md
Name: prio_event_encoder

Overview:
- Parametrised, registered successor to the team's 4:2 priority encoder.
- Captures single-cycle event pulses on WIDTH request lines into a sticky pending vector.
- Presents the highest-priority pending index with a valid flag, and clears that bit when the consumer acknowledges.
- Sits between event sources (key/sensor strobes, interrupt lines) and a sequential consumer that services one event at a time.

Parameters:
- WIDTH, 8, number of request lines; legal range 2..64.
- LSB_HIGH, 0, priority direction: 0 = highest index wins (matches the 4:2 encoder); 1 = lowest index wins.
- IDX_W, $clog2(WIDTH), localparam (not overridable); width of the index output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- d  input  WIDTH  event pulses; each high cycle sets the matching pending bit.
- ack  input  1  consumer accepts the current index; honoured only when v=1.
- clr  input  1  synchronous flush of pending and ovf.
- y  output  IDX_W  registered index of the winning pending bit.
- v  output  1  registered; high when any eligible bit is pending.
- pend  output  WIDTH  registered pending vector.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset: one clock, synchronous, active-low, as decided. rst_n=0 at an edge forces pend=0, y=0, v=0, ovf=0. Reset overrides clr, d and ack. Reset mid-service discards all pending events.
- Served vector: served = onehot(y) when (v & ack), else 0. ack with v=0 is ignored.
- Next pending: pend_n = clr ? 0 : (pend & ~served) | d.
- Same-edge set and clear: if d[y] and a serve of y occur on the same edge, set wins. The bit stays pending and ovf is not set.
- Registered outputs: y and v are computed from pend_n, so y/v always equal the encoding of the current pend register.
- Latency: a pulse on d at edge k gives v=1 and an updated y after edge k (1 cycle). An ack at edge k gives the next winner after edge k, so back-to-back acks service one event per cycle.
- Encoding: scan pend_n from bit WIDTH-1 down to 0 (LSB_HIGH=0), or from 0 up (LSB_HIGH=1). The first set bit gives y. If no bit is set, y=0 and v=0.
- Index width: y is IDX_W bits, so non-power-of-two WIDTH never produces an index above WIDTH-1.
- Overflow: ovf sets when d[i]=1, pend[i]=1 and bit i is not being served on that edge. ovf is cleared only by clr or reset. On a clr edge, d is ignored and ovf is not set.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PRIO_EVENT_ENCODER_MASK_EN.
- Defined:
  - Adds input port mask[WIDTH-1:0].
  - Masked bits are still captured in pend and still raise ovf, but are excluded from encoding: the winner comes from pend_n & ~mask, and v = |(pend_n & ~mask).
  - Unmasking a pending bit makes it eligible on the next edge.
- Undefined: no mask port; all bits are eligible.

Decomposition:
- Package prio_enc_pkg holds:
  - a clog2 constant function;
  - LSB_HIGH encodings (PRIO_MSB_FIRST=0, PRIO_LSB_FIRST=1);
  - the WIDTH limits (2, 64).
- Sub-module prio_enc_comb: purely combinational, WIDTH/LSB_HIGH-parameterised encoder. Input: vector. Outputs: idx, any.
- Top level holds pend, the served/ovf logic and the output registers.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with d=8'hFF, ack=1 -> pend=0, y=0, v=0, ovf=0; the next cycle after release captures d.
2. Basic service (WIDTH=8, LSB_HIGH=0): pulse d=8'h24 for one cycle.
   - Next cycle -> y=5, v=1, pend=8'h24.
   - ack -> y=2, pend=8'h04.
   - ack -> v=0, y=0, pend=0.
3. Set/serve collision: with pend=8'h20 and y=5, apply ack=1 and d=8'h20 together -> pend stays 8'h20, y=5, v=1, ovf=0.
4. Overflow and flush:
   - With pend=8'h04 and ack=0, pulse d=8'h04 -> ovf=1, and it holds for 10 cycles.
   - Assert clr with d=8'h01 -> pend=0, v=0, ovf=0.
5. LSB_HIGH=1 with d=8'h24 -> y=2 first, then 5 after ack. WIDTH=5 with d=5'b10000 -> y=3'd4, v=1.
6. PRIO_EVENT_ENCODER_MASK_EN defined:
   - pend=8'h24, mask=8'h20 -> y=2, v=1.
   - mask=8'h24 -> v=0, pend=8'h24.
   - Clearing mask -> y=5 after one edge.
